// File: rtl/tdm_demux_if.sv
// TDM demux bus: serial word/valid/sync in, parallel channel registers and status out.
// The slave modport is the demux side; the master modport is the link/driver side.
interface tdm_demux_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  logic [WIDTH-1:0]          din;
  logic                      din_valid;
  logic                      frame_sync;
  logic [CHANNELS*WIDTH-1:0] dout;
  logic [CHANNELS-1:0]       dout_valid;
  logic                      frame_done;
  logic                      sync_err;
  logic                      locked;

  modport master (
    output din, din_valid, frame_sync,
    input  dout, dout_valid, frame_done, sync_err, locked
  );

  modport slave (
    input  din, din_valid, frame_sync,
    output dout, dout_valid, frame_done, sync_err, locked
  );
endinterface

// File: rtl/tdm_demux.sv
// Registered TDM demultiplexer: steers one serial word per valid beat into its channel register.
// Optional TDM_DEMUX_FRAME_LATCH_EN double-buffers a whole frame and publishes it on frame_done.
module tdm_demux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  tdm_demux_if.slave  bus
);
  localparam int CW = $clog2(CHANNELS);
  localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_e;

  state_e                         state_q, state_d;
  logic [CW-1:0]                  ch_q, ch_d;
  logic [CHANNELS-1:0][WIDTH-1:0] dout_q, dout_d;
  logic [CHANNELS-1:0]            dv_q, dv_d;
  logic                           fd_q, fd_d;
  logic                           se_q, se_d;
  logic                           wr_en;
  logic [CW-1:0]                  wr_ch;
  logic                           resync;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HUNT;
    else        state_q <= state_d;
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    if (bus.din_valid) begin
      case (state_q)
        HUNT:    if (bus.frame_sync) state_d = LOCKED;
        LOCKED:  if (!bus.frame_sync && ch_q == '0) state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  // ---------------- output / datapath decode ----------------
  always_comb begin
    wr_en  = 1'b0;
    wr_ch  = '0;
    ch_d   = ch_q;
    fd_d   = 1'b0;
    se_d   = 1'b0;
    resync = 1'b0;
    if (bus.din_valid) begin
      case (state_q)
        HUNT: begin
          if (bus.frame_sync) begin
            wr_en = 1'b1;
            ch_d  = CW'(1);
          end
        end
        LOCKED: begin
          if (bus.frame_sync) begin
            // sync always restarts the frame at channel 0; only flag it when it came early
            wr_en  = 1'b1;
            ch_d   = CW'(1);
            se_d   = (ch_q != '0);
            resync = (ch_q != '0);
          end else if (ch_q == '0) begin
            se_d = 1'b1;
          end else begin
            wr_en = 1'b1;
            wr_ch = ch_q;
            ch_d  = ch_q + CW'(1);
            fd_d  = (ch_q == LAST);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TDM_DEMUX_FRAME_LATCH_EN
  logic [CHANNELS-1:0][WIDTH-1:0] shadow_q, shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    if (resync) shadow_d = '0;
    if (wr_en)  shadow_d[wr_ch] = bus.din;
    dout_d = fd_d ? shadow_d : dout_q;
    dv_d   = fd_d ? '1 : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shadow_q <= '0;
    else        shadow_q <= shadow_d;
  end
`else
  always_comb begin
    dout_d = dout_q;
    dv_d   = '0;
    if (wr_en) begin
      dout_d[wr_ch] = bus.din;
      dv_d[wr_ch]   = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q   <= '0;
      dout_q <= '0;
      dv_q   <= '0;
      fd_q   <= 1'b0;
      se_q   <= 1'b0;
    end else begin
      ch_q   <= ch_d;
      dout_q <= dout_d;
      dv_q   <= dv_d;
      fd_q   <= fd_d;
      se_q   <= se_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dv_q;
  assign bus.frame_done = fd_q;
  assign bus.sync_err   = se_q;
  assign bus.locked     = (state_q == LOCKED);
endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed test-plan scenarios plus randomized beats
// compared every cycle against a frame-level reference model.
module tb_tdm_demux;
  localparam int W  = 8;
  localparam int CH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tdm_demux_if #(.WIDTH(W), .CHANNELS(CH)) bus ();
  tdm_demux #(.WIDTH(W), .CHANNELS(CH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int se_cnt = 0;

  // reference model state
  bit             m_locked;
  int             m_ch;
  logic [W-1:0]   m_dout   [CH];
  logic [W-1:0]   m_shadow [CH];
  logic [CH-1:0]  e_dv;
  bit             e_fd, e_se;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CH*W-1:0] flat_dout();
    logic [CH*W-1:0] f;
    for (int k = 0; k < CH; k++) f[k*W +: W] = m_dout[k];
    return f;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".dout"},   64'(bus.dout),       64'(flat_dout()));
    chk({tag, ".dv"},     64'(bus.dout_valid), 64'(e_dv));
    chk({tag, ".fdone"},  64'(bus.frame_done), 64'(e_fd));
    chk({tag, ".serr"},   64'(bus.sync_err),   64'(e_se));
    chk({tag, ".locked"}, 64'(bus.locked),     64'(m_locked));
  endtask

  task automatic model_reset();
    m_locked = 0; m_ch = 0; e_dv = '0; e_fd = 0; e_se = 0;
    for (int k = 0; k < CH; k++) begin m_dout[k] = '0; m_shadow[k] = '0; end
  endtask

  // Store a word for channel k; in frame-latch mode it only reaches dout on frame completion.
  task automatic model_store(input int k, input logic [W-1:0] d);
`ifdef TDM_DEMUX_FRAME_LATCH_EN
    m_shadow[k] = d;
`else
    m_dout[k] = d;
    e_dv[k]   = 1'b1;
`endif
  endtask

  task automatic model_step(input bit v, input bit s, input logic [W-1:0] d);
    e_dv = '0; e_fd = 0; e_se = 0;
    if (!v) return;
    if (!m_locked) begin
      if (s) begin model_store(0, d); m_ch = 1; m_locked = 1; end
    end else if (s) begin
      if (m_ch != 0) begin
        e_se = 1;
        for (int k = 0; k < CH; k++) m_shadow[k] = '0;
      end
      model_store(0, d);
      m_ch = 1;
    end else if (m_ch == 0) begin
      e_se = 1; m_locked = 0;
    end else begin
      model_store(m_ch, d);
      if (m_ch == CH - 1) begin
        e_fd = 1; m_ch = 0;
`ifdef TDM_DEMUX_FRAME_LATCH_EN
        for (int k = 0; k < CH; k++) m_dout[k] = m_shadow[k];
        e_dv = '1;
`endif
      end else m_ch++;
    end
  endtask

  task automatic beat(input string tag, input bit v, input bit s, input logic [W-1:0] d);
    @(negedge clk);
    bus.din_valid = v; bus.frame_sync = s; bus.din = d;
    @(posedge clk);
    model_step(v, s, d);
    #1;
    if (bus.frame_done === 1'b1) fd_cnt++;
    if (bus.sync_err === 1'b1)   se_cnt++;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) beat(tag, 1'b0, 1'($urandom_range(0, 1)), W'($urandom));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.din_valid = 1'b0; bus.frame_sync = 1'b0; bus.din = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) rst_n = 1'b1;

    // hunt: unsynced words dropped, then first frame
    beat("hunt", 1, 0, 8'h11);
    beat("hunt", 1, 0, 8'h22);
    fd_cnt = 0;
    beat("hunt", 1, 1, 8'hA0);
    beat("hunt", 1, 0, 8'hA1);
    beat("hunt", 1, 0, 8'hA2);
    beat("hunt", 1, 0, 8'hA3);
    chk("hunt.frame", 64'(bus.dout), 64'h A3A2A1A0);
    chk("hunt.fdcnt", 64'(fd_cnt), 64'd1);

    // gaps: idle beats with random sync/data must be ignored
    fd_cnt = 0;
    beat("gap", 1, 1, 8'hA0); idle("gap", 3);
    beat("gap", 1, 0, 8'hA1); idle("gap", 3);
    beat("gap", 1, 0, 8'hA2); idle("gap", 3);
    beat("gap", 1, 0, 8'hA3); idle("gap", 3);
    chk("gap.frame", 64'(bus.dout), 64'h A3A2A1A0);
    chk("gap.fdcnt", 64'(fd_cnt), 64'd1);

    // early sync
    se_cnt = 0;
    beat("early", 1, 1, 8'hB0);
    beat("early", 1, 0, 8'hB1);
    beat("early", 1, 1, 8'hC0);
`ifdef TDM_DEMUX_FRAME_LATCH_EN
    chk("early.hold", 64'(bus.dout), 64'h A3A2A1A0);
`else
    chk("early.ch0", 64'(bus.dout[7:0]), 64'h C0);
`endif
    beat("early", 1, 0, 8'hC1);
`ifndef TDM_DEMUX_FRAME_LATCH_EN
    chk("early.ch1", 64'(bus.dout[15:8]), 64'h C1);
`endif
    beat("early", 1, 0, 8'hC2);
    beat("early", 1, 0, 8'hC3);
    chk("early.frame", 64'(bus.dout), 64'h C3C2C1C0);
    chk("early.secnt", 64'(se_cnt), 64'd1);

    // missing sync then relock
    beat("miss", 1, 0, 8'hD0);
    chk("miss.locked", 64'(bus.locked), 64'd0);
    chk("miss.kept", 64'(bus.dout), 64'h C3C2C1C0);
    beat("relock", 1, 1, 8'hE0);
    beat("relock", 1, 0, 8'hE1);
    beat("relock", 1, 0, 8'hE2);
    beat("relock", 1, 0, 8'hE3);
    chk("relock.frame", 64'(bus.dout), 64'h E3E2E1E0);

    // full-rate: 3 back-to-back frames
    fd_cnt = 0; se_cnt = 0;
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < CH; k++) beat("full", 1, (k == 0), W'($urandom));
    chk("full.fdcnt", 64'(fd_cnt), 64'd3);
    chk("full.secnt", 64'(se_cnt), 64'd0);

    // randomized traffic, mostly well-formed with occasional sync faults
    for (int i = 0; i < 300; i++) begin
      bit v, s;
      v = ($urandom_range(0, 3) != 0);
      if (!m_locked || m_ch == 0) s = ($urandom_range(0, 7) != 0);
      else                        s = ($urandom_range(0, 9) == 0);
      beat("rand", v, s, W'($urandom));
    end

    // mid-frame reset
    beat("prerst", 1, 1, 8'h5A);
    beat("prerst", 1, 0, 8'h6B);
    @(negedge clk);
    bus.din_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("midrst");
    @(negedge clk) rst_n = 1'b1;
    beat("postrst", 1, 0, 8'h77);
    beat("postrst", 1, 0, 8'h88);
    beat("postrst", 1, 1, 8'h90);
    beat("postrst", 1, 0, 8'h91);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
